pc_fetch_unit: RTL

Instruction-fetch stage for the MIPS core. Holds the program counter, fetches from instruction memory using a req/ack handshake, and hands each fetched instruction to decode using a valid/ready handshake. It supplies the PC+4 upper nibble and the 26-bit instr index to the jump-address builder. It consumes the resulting jump target, plus branch and jr redirects, to steer the next fetch.

---
 rtl/pc_fetch_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction-fetch stage for the MIPS core. Holds the program counter,
// fetches one word at a time from instruction memory with a req/ack
// handshake, and presents it to decode with a valid/ready handshake.
// Branch, jump and jr redirects steer the next fetch. A misaligned jr target
// parks the unit in HALT until reset.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   imem_req/addr       fetch request and address (address = pc)
//   imem_ack/rdata      memory response, rdata valid when ack=1
//   if_valid/ready      handshake to decode
//   if_instr/pc/pc4     held instruction, its address, and address + 4
//   jaddr_pc_hi/index   fields for the jump-address builder
//   redirect_*          control-flow change request and its operands
//   branch_offset       sign-extended 16-bit word offset
//   jump_target         result of the jump-address builder
//   jr_target           register operand for jr
//   misalign_err        sticky flag, set when a jr target is misaligned
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic [3:0]  jaddr_pc_hi,
    output logic [25:0] jaddr_index,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_sel,
    input  logic [31:0] redirect_pc4,
    input  logic [31:0] branch_offset,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        HOLD  = 2'b01,
        HALT  = 2'b10
    } state_t;

    localparam logic [1:0] SEL_NONE   = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;
    localparam logic [1:0] SEL_JR     = 2'b11;

    state_t      state;
    logic [31:0] pc;

    logic        redirect_take;
    logic        jr_misaligned;
    logic [31:0] redirect_target;

    // The top two offset bits shift out of the word-to-byte conversion.
    logic        unused_offset_bits;
    assign unused_offset_bits = ^branch_offset[31:30];

    // Redirect wins over both the memory ack and the decode handshake; a
    // halted unit ignores redirects entirely.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        redirect_target = pc;
        jr_misaligned   = 1'b0;
        redirect_take   = redirect_valid && (redirect_sel != SEL_NONE) && (state != HALT);
        case (redirect_sel)
            SEL_BRANCH: redirect_target = redirect_pc4 + {branch_offset[29:0], 2'b00};
            SEL_JUMP:   redirect_target = jump_target;
            SEL_JR: begin
                redirect_target = jr_target;
                jr_misaligned   = (jr_target[1:0] != 2'b00);
            end
            default:    redirect_target = pc;
        endcase
    end

    // Request is gated by rst_n directly so the memory never sees a request
    // during reset, even before the first edge has cleared the state.
    assign imem_req  = rst_n && (state == FETCH);
    assign imem_addr = pc;

    assign jaddr_pc_hi = if_pc4[31:28];
    assign jaddr_index = if_instr[25:0];

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            if_valid     <= 1'b0;
            if_instr     <= 32'h0;
            if_pc        <= 32'h0;
            if_pc4       <= 32'h0;
            misalign_err <= 1'b0;
        end else if (redirect_take) begin
            // Squash whatever is held; any ack this cycle is discarded.
            if_valid <= 1'b0;
            if (jr_misaligned) begin
                state        <= HALT;
                misalign_err <= 1'b1;
            end else begin
                state <= FETCH;
                pc    <= redirect_target;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        if_instr <= imem_rdata;
                        if_pc    <= pc;
                        if_pc4   <= pc + 32'd4;
                        pc       <= pc + 32'd4;
                        if_valid <= 1'b1;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (if_ready) begin
                        if_valid <= 1'b0;
                        state    <= FETCH;
                    end
                end
                HALT: begin
                    if_valid     <= 1'b0;
                    misalign_err <= 1'b1;
                end
                default: begin
                    state    <= FETCH;
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
